// File: rtl/gated_reg_bank.sv
// -----------------------------------------------------------------------------
// gated_reg_bank
//
// Bank of CHANNELS independent WIDTH-bit registers. Each channel either loads
// its slice of d_in (mode = 0) or shifts left, taking ser_in[i] as the new LSB
// (mode = 1). A write only happens when the channel is requested (en[i]) and
// the new value actually differs from the stored one. Writes that would not
// change the value are suppressed, so the per-channel enable can map onto one
// integrated clock gate per channel. Each channel also keeps a saturating
// activity counter that counts the edges on which it was really written.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset (deassertion synchronised outside)
//   en       : per-channel write request
//   mode     : 0 = parallel load, 1 = serial shift (applies to all channels)
//   d_in     : parallel data, channel i in bits [i*WIDTH +: WIDTH]
//   ser_in   : serial input bit per channel
//   out      : channel registers, same packing as d_in
//   gated    : bit i = 1 when channel i was not written on the previous edge
//   cnt_sel  : selects the channel for act_cnt and cnt_clr
//   cnt_clr  : synchronous clear of the selected channel's activity counter
//   act_cnt  : combinational read of the selected channel's activity counter
// -----------------------------------------------------------------------------
module gated_reg_bank #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [CHANNELS-1:0]                               en,
  input  logic                                              mode,
  input  logic [CHANNELS*WIDTH-1:0]                         d_in,
  input  logic [CHANNELS-1:0]                               ser_in,
  output logic [CHANNELS*WIDTH-1:0]                         out,
  output logic [CHANNELS-1:0]                               gated,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cnt_sel,
  input  logic                                              cnt_clr,
  output logic [CNT_W-1:0]                                  act_cnt
);

  // A single channel still needs a one-bit select; selects that do not name
  // an existing channel simply never match any channel index below.
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]    out_q [CHANNELS];
  logic [WIDTH-1:0]    out_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CHANNELS-1:0] gated_q;
  logic [CHANNELS-1:0] gated_d;
  logic [CHANNELS-1:0] ge;
  logic [CHANNELS-1:0] clr_hit;

  // Candidate next value per channel and the resulting gate enable.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode) begin
        out_d[i] = {out_q[i][WIDTH-2:0], ser_in[i]};
      end else begin
        out_d[i] = d_in[i*WIDTH +: WIDTH];
      end
      // A write that would store the value already held is dropped.
      ge[i] = en[i] & (out_d[i] != out_q[i]);
    end
  end

  // Gated flag is the complement of this edge's enable.
  always_comb begin
    gated_d = ~ge;
  end

  // Which channel (if any) the clear request targets this cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      clr_hit[i] = cnt_clr & (cnt_sel == SEL_W'(i));
    end
  end

  // Activity counters: clear beats increment, increment saturates.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr_hit[i]) begin
        cnt_d[i] = {CNT_W{1'b0}};
      end else if (ge[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Channel data flops, one enable per channel shared by all of its bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        out_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ge[i]) begin
          out_q[i] <= out_d[i];
        end else begin
          out_q[i] <= out_q[i];
        end
      end
    end
  end

  // Gated flags and activity counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_q <= {CHANNELS{1'b1}};
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      gated_q <= gated_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pack channel registers onto the flat output bus.
  always_comb begin
    out = {(CHANNELS*WIDTH){1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      out[i*WIDTH +: WIDTH] = out_q[i];
    end
  end

  // Gated flags drive the port straight from their flops.
  always_comb begin
    gated = gated_q;
  end

  // Counter read mux: an out-of-range select matches nothing and reads zero.
  always_comb begin
    act_cnt = {CNT_W{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      act_cnt = act_cnt | (cnt_q[i] & {CNT_W{cnt_sel == SEL_W'(i)}});
    end
  end

endmodule

// File: tb/tb_gated_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_gated_reg_bank
//
// Directed bench for gated_reg_bank. Two instances share every input: one with
// the default 16-bit counters and one with 2-bit counters so saturation can be
// reached quickly. A short randomised phase at the end compares against a
// small behavioural model of the bank.
// -----------------------------------------------------------------------------
module tb_gated_reg_bank;

  logic        clk;
  logic        rst_n;
  logic [3:0]  en;
  logic        mode;
  logic [19:0] d_in;
  logic [3:0]  ser_in;
  logic [1:0]  cnt_sel;
  logic        cnt_clr;

  logic [19:0] out1, out2;
  logic [3:0]  gated1, gated2;
  logic [15:0] act1;
  logic [1:0]  act2;

  int checks   = 0;
  int failures = 0;

  // model state for the randomised phase
  logic [4:0]  m_out [4];
  logic [4:0]  m_nxt;
  logic        m_ge;
  logic [3:0]  m_gated;
  int          m_cnt  [4];
  int          m_cnt2 [4];
  logic [19:0] m_pack;

  gated_reg_bank #(.WIDTH(5), .CHANNELS(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d_in(d_in),
    .ser_in(ser_in), .out(out1), .gated(gated1), .cnt_sel(cnt_sel),
    .cnt_clr(cnt_clr), .act_cnt(act1)
  );

  gated_reg_bank #(.WIDTH(5), .CHANNELS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d_in(d_in),
    .ser_in(ser_in), .out(out2), .gated(gated2), .cnt_sel(cnt_sel),
    .cnt_clr(cnt_clr), .act_cnt(act2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [1:0] sel,
                         input int exp1, input int exp2);
    cnt_sel = sel;
    #1;
    chk({tag, "_cnt16"}, {16'd0, act1}, exp1);
    chk({tag, "_cnt2"},  {30'd0, act2}, exp2);
  endtask

  initial begin
    rst_n = 1'b1; en = 4'd0; mode = 1'b0; d_in = 20'd0; ser_in = 4'd0;
    cnt_sel = 2'd0; cnt_clr = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out", {12'd0, out1}, 32'h0);
    chk("rst_gated", {28'd0, gated1}, 32'hF);
    chk_cnt("rst", 2'd0, 0, 0);
    tick();
    chk("rst_hold_out", {12'd0, out1}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    // parallel load on ch0
    en = 4'b0001; mode = 1'b0; d_in = 20'h00016;
    tick();
    chk("load_out", {12'd0, out1}, 32'h00016);
    chk("load_gated", {28'd0, gated1}, 32'hE);
    chk_cnt("load_c0", 2'd0, 1, 1);
    chk_cnt("load_c1", 2'd1, 0, 0);

    // redundant writes are suppressed
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("redund_out", {12'd0, out1}, 32'h00016);
      chk("redund_gated", {28'd0, gated1}, 32'hF);
    end
    chk_cnt("redund_c0", 2'd0, 1, 1);

    // preload ch1 = 00001, then shift ones in
    en = 4'b0010; d_in = 20'h00036;
    tick();
    chk("pre1_out", {12'd0, out1}, 32'h00036);
    chk("pre1_gated", {28'd0, gated1}, 32'hD);
    mode = 1'b1; ser_in = 4'b0010;
    tick();
    chk("shift1_out", {12'd0, out1}, 32'h00076);
    tick();
    chk("shift2_out", {12'd0, out1}, 32'h000F6);
    chk("shift2_gated", {28'd0, gated1}, 32'hD);
    chk_cnt("shift_c1", 2'd1, 3, 3);

    // clear ch1 by parallel load, then a zero shift into zero is gated
    mode = 1'b0; ser_in = 4'b0000; d_in = 20'h00016;
    tick();
    chk("zero1_out", {12'd0, out1}, 32'h00016);
    chk_cnt("zero1_c1", 2'd1, 4, 3);
    mode = 1'b1;
    tick();
    chk("shift0_out", {12'd0, out1}, 32'h00016);
    chk("shift0_gated", {28'd0, gated1}, 32'hF);
    chk_cnt("shift0_c1", 2'd1, 4, 3);

    // toggle ch2 for five edges: 2-bit counter saturates at 3
    mode = 1'b0; en = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      d_in = (k % 2 == 0) ? 20'h00416 : 20'h00816;
      tick();
    end
    chk("tog_out", {12'd0, out1}, 32'h00416);
    chk_cnt("tog_c2", 2'd2, 5, 3);

    // clear wins over a simultaneous increment
    cnt_sel = 2'd2; cnt_clr = 1'b1; d_in = 20'h00816;
    tick();
    cnt_clr = 1'b0;
    chk("clr_out", {12'd0, out1}, 32'h00816);
    chk("clr_gated", {28'd0, gated1}, 32'hB);
    chk_cnt("clr_c2", 2'd2, 0, 0);
    tick();
    chk_cnt("clr_hold_c2", 2'd2, 0, 0);

    // clear of ch0 leaves the simultaneously written ch1 untouched
    cnt_sel = 2'd0; cnt_clr = 1'b1; en = 4'b0010; d_in = 20'h008B6;
    tick();
    cnt_clr = 1'b0;
    chk("iso_out", {12'd0, out1}, 32'h008B6);
    chk_cnt("iso_c0", 2'd0, 0, 0);
    chk_cnt("iso_c1", 2'd1, 5, 3);
    chk_cnt("iso_c3", 2'd3, 0, 0);

    // mode change applies on the same edge: ch0 10110 -> 01101
    mode = 1'b1; en = 4'b0001; ser_in = 4'b0001;
    tick();
    chk("mode_out", {12'd0, out1}, 32'h008AD);
    chk_cnt("mode_c0", 2'd0, 1, 1);

    // asynchronous reset between edges while every channel is requesting
    mode = 1'b0; en = 4'b1111; ser_in = 4'b0000; d_in = 20'hFD547;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out", {12'd0, out1}, 32'h0);
    chk("arst_gated", {28'd0, gated1}, 32'hF);
    for (int c = 0; c < 4; c++) chk_cnt("arst", 2'(c), 0, 0);
    tick();
    chk("arst_edge_out", {12'd0, out1}, 32'h0);
    chk("arst_edge_gated", {28'd0, gated1}, 32'hF);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_out", {12'd0, out1}, 32'hFD547);
    chk("post_rst_gated", {28'd0, gated1}, 32'h0);
    chk("post_rst_out2", {12'd0, out2}, 32'hFD547);
    for (int c = 0; c < 4; c++) chk_cnt("post_rst", 2'(c), 1, 1);

    // randomised phase against a behavioural model
    @(negedge clk);
    rst_n = 1'b0; en = 4'd0; cnt_clr = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_out[i] = 5'd0; m_cnt[i] = 0; m_cnt2[i] = 0;
    end
    m_gated = 4'hF;
    for (int c = 0; c < 400; c++) begin
      en      = 4'($urandom);
      mode    = 1'($urandom);
      d_in    = 20'($urandom);
      ser_in  = 4'($urandom);
      cnt_sel = 2'($urandom);
      cnt_clr = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 4; i++) begin
        m_nxt = mode ? {m_out[i][3:0], ser_in[i]} : d_in[i*5 +: 5];
        m_ge  = en[i] && (m_nxt != m_out[i]);
        m_gated[i] = !m_ge;
        if (m_ge) m_out[i] = m_nxt;
        if (cnt_clr && (int'(cnt_sel) == i)) begin
          m_cnt[i] = 0; m_cnt2[i] = 0;
        end else if (m_ge) begin
          if (m_cnt[i] < 65535) m_cnt[i]++;
          if (m_cnt2[i] < 3) m_cnt2[i]++;
        end
      end
      m_pack = {m_out[3], m_out[2], m_out[1], m_out[0]};
      tick();
      chk("rnd_out", {12'd0, out1}, {12'd0, m_pack});
      chk("rnd_gated", {28'd0, gated1}, {28'd0, m_gated});
      chk("rnd_cnt16", {16'd0, act1}, m_cnt[cnt_sel]);
      chk("rnd_cnt2", {30'd0, act2}, m_cnt2[cnt_sel]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
